adder_seq: RTL and testbench

//   Multi-byte add/subtract sequencer built around one adder8 instance.

---
 rtl/adder_seq.sv | 139 +++++++++++++
 tb/tb_adder_seq.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/adder_seq.sv
// adder_seq: multi-byte add/subtract sequencer that streams NBYTES-wide
// operands through a single 8-bit adder, LSB byte first, one byte per clock.
// Operand and result vectors use [0:W-1] ordering (index 0 = MSB).
// Optional feature: define ADDSEQ_OVF_EN to add the signed-overflow output ovf.

// adder8: 8-bit adder with carry in/out, bit 0 is the MSB
module adder8 (
  input  logic [0:7] a,
  input  logic [0:7] b,
  input  logic       cin,
  output logic [0:7] s,
  output logic       cout
);
  assign {cout, s} = {1'b0, a} + {1'b0, b} + {8'b0, cin};
endmodule

module adder_seq #(
  parameter int NBYTES = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            sub,
  input  logic            cin,
  input  logic [0:8*NBYTES-1] a,
  input  logic [0:8*NBYTES-1] b,
  output logic            ready,
  output logic            busy,
  output logic            done,
  output logic [0:8*NBYTES-1] s,
  output logic            cout
`ifdef ADDSEQ_OVF_EN
  ,output logic           ovf
`endif
);
  localparam int W  = 8 * NBYTES;
  localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [0:W-1]  a_reg;
  logic [0:W-1]  b_reg;
  logic          carry;

  logic [0:7]    a_byte;
  logic [0:7]    b_byte;
  logic [0:7]    sum_byte;
  logic          sum_carry;
  logic          last;

  // Select the operand byte addressed by cnt (cnt=0 is the LSB byte)
  always_comb begin
    a_byte = '0;
    b_byte = '0;
    for (int k = 0; k < NBYTES; k++) begin
      if (cnt == CW'(k)) begin
        a_byte = a_reg[W-8*(k+1) +: 8];
        b_byte = b_reg[W-8*(k+1) +: 8];
      end
    end
  end

  assign last = (cnt == CW'(NBYTES - 1));

  adder8 u_adder8 (
    .a    (a_byte),
    .b    (b_byte),
    .cin  (carry),
    .s    (sum_byte),
    .cout (sum_carry)
  );

  // Sequencer FSM: latch operands, step bytes through the adder, pulse done
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      carry <= 1'b0;
      a_reg <= '0;
      b_reg <= '0;
      ready <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
      s     <= '0;
      cout  <= 1'b0;
`ifdef ADDSEQ_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg <= a;
            b_reg <= sub ? ~b : b;
            carry <= cin ^ sub;
            cnt   <= '0;
            state <= RUN;
            ready <= 1'b0;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          for (int k = 0; k < NBYTES; k++) begin
            if (cnt == CW'(k)) begin
              s[W-8*(k+1) +: 8] <= sum_byte;
            end
          end
          carry <= sum_carry;
          if (last) begin
            cout  <= sum_carry;
`ifdef ADDSEQ_OVF_EN
            ovf   <= (a_reg[0] == b_reg[0]) && (sum_byte[0] != a_reg[0]);
`endif
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_adder_seq.sv
// tb_adder_seq: scoreboard bench for adder_seq with NBYTES=4.
// Stimulus pushes hand-computed results into a queue; a monitor pops and
// compares whenever done pulses. Define ADDSEQ_OVF_EN to also check ovf.
module tb_adder_seq;
  localparam int NB = 4;
  localparam int W  = 8 * NB;

  typedef struct {
    string      name;
    logic [31:0] s;
    logic        cout;
    logic        ovf;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          sub = 1'b0;
  logic          cin = 1'b0;
  logic [0:W-1]  a = '0;
  logic [0:W-1]  b = '0;
  logic          ready;
  logic          busy;
  logic          done;
  logic [0:W-1]  s;
  logic          cout;
`ifdef ADDSEQ_OVF_EN
  logic          ovf;
`endif

  exp_t expq[$];
  int   tests  = 0;
  int   failed = 0;
  int   pushed = 0;
  int   dones  = 0;

  adder_seq #(.NBYTES(NB)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sub   (sub),
    .cin   (cin),
    .a     (a),
    .b     (b),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .s     (s),
    .cout  (cout)
`ifdef ADDSEQ_OVF_EN
    ,.ovf  (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic checkResetState(input string name);
    checkOutput({name, " ready"}, 32'(ready), 32'd1);
    checkOutput({name, " busy"},  32'(busy),  32'd0);
    checkOutput({name, " done"},  32'(done),  32'd0);
    checkOutput({name, " s"},     32'(s),     32'd0);
    checkOutput({name, " cout"},  32'(cout),  32'd0);
`ifdef ADDSEQ_OVF_EN
    checkOutput({name, " ovf"},   32'(ovf),   32'd0);
`endif
  endtask

  // Monitor: every done pulse pops one expected result and compares it
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && done) begin
        dones++;
        if (expq.size() == 0) begin
          checkOutput("unexpected done", 32'd1, 32'd0);
        end else begin
          e = expq.pop_front();
          checkOutput({e.name, " s"},    32'(s),    e.s);
          checkOutput({e.name, " cout"}, 32'(cout), 32'(e.cout));
`ifdef ADDSEQ_OVF_EN
          checkOutput({e.name, " ovf"},  32'(ovf),  32'(e.ovf));
`endif
        end
      end
    end
  end

  task automatic waitReady(input string name);
    int n;
    n = 0;
    while (!ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!ready) checkOutput({name, " ready timeout"}, 32'd0, 32'd1);
  endtask

  // Issue one operation; optionally pulse start during RUN and DONE
  task automatic applyStimulus(input string name, input logic [31:0] va, input logic [31:0] vb,
                               input logic vsub, input logic vcin,
                               input logic [31:0] es, input logic ec, input logic eo,
                               input bit pulse);
    exp_t e;
    logic [NB-1:0] busy_seen;
    logic          done_last;
    logic          busy_last;
    waitReady(name);
    a = va; b = vb; sub = vsub; cin = vcin; start = 1'b1;
    e.name = name; e.s = es; e.cout = ec; e.ovf = eo;
    expq.push_back(e);
    pushed++;
    @(negedge clk);
    start = 1'b0;
    a = 32'hDEAD_BEEF; b = 32'h1234_5678; sub = ~vsub; cin = ~vcin;
    busy_seen = '0;
    for (int i = 0; i < NB; i++) begin
      busy_seen[i] = busy;
      start = pulse && (i == 1);
      @(negedge clk);
    end
    busy_last = busy;
    done_last = done;
    start = pulse;
    @(negedge clk);
    start = 1'b0;
    checkOutput({name, " latency"}, 32'({busy_seen, busy_last, done_last}),
                32'({{NB{1'b1}}, 1'b0, 1'b1}));
  endtask

  initial begin
    $display("[TB] adder_seq scoreboard bench, NBYTES=%0d", NB);
    repeat (3) @(negedge clk);
    checkResetState("power-on reset");
    rst = 1'b0;
    @(negedge clk);

    applyStimulus("ff+1",        32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0);
    applyStimulus("wrap b=1",    32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
    applyStimulus("wrap cin=1",  32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
    applyStimulus("sub 5-7",     32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    applyStimulus("sub 7-5",     32'h0000_0007, 32'h0000_0005, 1'b1, 1'b0, 32'h0000_0002, 1'b1, 1'b0, 1'b0);
    applyStimulus("mixed add",   32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0, 32'hACF1_3568, 1'b0, 1'b0, 1'b0);
    applyStimulus("sub borrow",  32'h0000_0010, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_000C, 1'b1, 1'b0, 1'b0);
    applyStimulus("pos ovf",     32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    applyStimulus("neg ovf sub", 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    applyStimulus("start ignored", 32'h0001_0000, 32'h0002_0000, 1'b0, 1'b0, 32'h0003_0000, 1'b0, 1'b0, 1'b1);
    repeat (8) @(negedge clk);
    checkOutput("single done", 32'(dones), 32'(pushed));

    // Reset while idle, after results are held
    rst = 1'b1;
    #1;
    checkResetState("idle reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset mid-run at cnt=2, then a fresh operation must be correct
    waitReady("abort");
    a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; sub = 1'b0; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    checkResetState("run reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    applyStimulus("after reset", 32'h1111_1111, 32'h2222_2222, 1'b0, 1'b1, 32'h3333_3334, 1'b0, 1'b0, 1'b0);

    repeat (8) @(negedge clk);
    checkOutput("queue drained", 32'(expq.size()), 32'd0);
    checkOutput("done count", 32'(dones), 32'(pushed));
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
